mod_if: RTL
===========

// Module: mod_if
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register; the producer side of the decode interface.
//  Owns the PC, issues requests to a variable-latency instruction memory and presents
//  instruction and pc (PC+2) to the decode stage.
//  Accepts stall from the hazard logic and redirect (flush + redirect_pc) from branch resolution.
//  Stops fetching after a HALT opcode.
// PARAMETERS
//  RESET_PC     16'h0000  byte address of first fetch after reset (bit 0 must be 0)
//  HALT_OPCODE  4'hF      instruction[15:12] value that stops fetch
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous reset, active-high
//  stall        in   1   hold IF/ID register and fetch
//  flush        in   1   squash IF/ID contents and redirect fetch
//  redirect_pc  in   16  new fetch address when flush=1; bit 0 ignored (forced 0)
//  imem_req     out  1   fetch request
//  imem_addr    out  16  fetch byte address; stable while imem_req=1
//  imem_ready   in   1   memory completes the request this cycle; may be high in first req cycle
//  imem_data    in   16  instruction word; valid when imem_ready=1
//  instruction  out  16  IF/ID instruction; 16'h0000 when if_valid=0
//  pc           out  16  IF/ID PC+2 of instruction
//  if_valid     out  1   IF/ID holds a real instruction
//  halted       out  1   fetch stopped by HALT
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - state=FETCH; PC and req_addr = RESET_PC
//   - instruction, pc, if_valid, halted = 0; imem_req=0 while rst=1
//  Priority at every edge: rst > flush > stall > normal.
//  Transfer: one transfer per cycle with imem_req=1 and imem_ready=1.
//   - imem_addr = req_addr, held constant until the transfer
//   - No request cancellation.
//  States (imem_req=1 in FETCH and DRAIN only):
//   FETCH: request at req_addr.
//    - ready & flush: drop data; PC, req_addr <= redirect_pc; stay FETCH.
//    - ready & stall: data to skid buffer; PC <= PC+2; go HOLD.
//    - ready, no stall: IF/ID <= {data, PC+2, valid=1}; PC, req_addr <= PC+2;
//      go HALT if data[15:12]==HALT_OPCODE, else stay FETCH.
//    - no ready & flush: PC <= redirect_pc; go DRAIN. req_addr unchanged.
//    - no ready, no flush: stay.
//   DRAIN: old request still held.
//    - Further flush updates PC to the newest redirect_pc.
//    - On ready: data dropped; req_addr <= PC; go FETCH.
//   HOLD: buffered word waits.
//    - stall=0: IF/ID <= buffer; go HALT if buffer is HALT, else FETCH with req_addr <= PC.
//    - flush: buffer dropped; PC, req_addr <= redirect_pc; go FETCH.
//   HALT: halted=1 from the cycle after the HALT word loads IF/ID.
//    - flush: halted <= 0; PC, req_addr <= redirect_pc; go FETCH (covers HALT in a branch shadow).
//    - Otherwise only rst leaves HALT.
//  IF/ID register:
//   - flush: if_valid=0, instruction=0 next cycle, regardless of stall.
//   - stall without flush: holds all fields.
//   - Not stalled and no transfer loaded: bubble (if_valid=0, instruction=0, pc unchanged).
//  The HALT word itself is delivered with if_valid=1.
//  Arithmetic: PC+2 is modulo 2^16 (16'hFFFE -> 16'h0000). No instruction lost or duplicated under any stall/ready overlap.
//  Zero-wait memory gives back-to-back fetch: one instruction per cycle, 1-cycle fetch-to-IF/ID latency.
// TESTING
//  1. Zero-wait memory (ready=1 always), words A,B,C at 0,2,4
//     -> imem_addr 0,2,4 on consecutive cycles; IF/ID (A,2),(B,4),(C,6) with if_valid=1 back-to-back.
//  2. ready delayed 3 cycles for addr 0x0002
//     -> imem_addr=0x0002 stable 3 cycles; if_valid=0 for 2 bubble cycles; then (B,0x0004).
//  3. stall=1 for 2 cycles coinciding with ready for B
//     -> IF/ID holds A; B buffered (HOLD, imem_req=0); B appears when stall drops; C fetched next; no duplicates.
//  4. flush with redirect_pc=16'h0041 while request for 0x0004 is outstanding
//     -> if_valid=0 next cycle; stale word dropped; next imem_addr=0x0040.
//  5. 16'hF000 at 0x0006
//     -> delivered with if_valid=1, pc=0x0008; halted=1; imem_req stays 0.
//     Then flush to 0x0010 -> halted=0, fetch at 0x0010.
//  6. RESET_PC=16'hFFFE -> fetch addresses FFFE then 0000, pc outputs 0000 then 0002.
//     rst during DRAIN -> all outputs at reset values; next request at RESET_PC.

Source files
------------

// File: rtl/mod_if_if.sv
// ============================================================================
// mod_if_if : instruction-memory request/response bus for the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface mod_if_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_data
   );
endinterface

`default_nettype wire

// File: rtl/mod_if.sv
// ============================================================================
// mod_if : instruction fetch with skid buffer, redirect drain and IF/ID register
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_if #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        stall,
   input  wire logic        flush,
   input  wire logic [15:0] redirect_pc,
   mod_if_if.master         imem,
   output logic      [15:0] instruction,
   output logic      [15:0] pc,
   output logic             if_valid,
   output logic             halted
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] req_addr_q, req_addr_d;
   logic [15:0] buf_q, buf_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] out_pc_q, out_pc_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;

   logic [15:0] redirect_even;
   logic [15:0] pc_plus2;
   logic        data_is_halt;
   logic        buf_is_halt;

   assign redirect_even = redirect_pc & 16'hFFFE;
   assign pc_plus2      = pc_q + 16'd2;
   assign data_is_halt  = (imem.imem_data[15:12] == HALT_OPCODE);
   assign buf_is_halt   = (buf_q[15:12] == HALT_OPCODE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         buf_q      <= 16'h0000;
         instr_q    <= 16'h0000;
         out_pc_q   <= 16'h0000;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         buf_q      <= buf_d;
         instr_q    <= instr_d;
         out_pc_q   <= out_pc_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (imem.imem_ready) begin
               if (flush)             state_d = S_FETCH;
               else if (stall)        state_d = S_HOLD;
               else if (data_is_halt) state_d = S_HALT;
               else                   state_d = S_FETCH;
            end else if (flush) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (imem.imem_ready) state_d = S_FETCH;
         end
         S_HOLD: begin
            if (flush)       state_d = S_FETCH;
            else if (!stall) state_d = buf_is_halt ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            if (flush) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      buf_d      = buf_q;
      instr_d    = instr_q;
      out_pc_d   = out_pc_q;
      valid_d    = valid_q;
      halted_d   = halted_q;

      // IF/ID becomes a bubble unless held by stall; loads below override
      if (flush || !stall) begin
         valid_d = 1'b0;
         instr_d = 16'h0000;
      end

      case (state_q)
         S_FETCH: begin
            if (imem.imem_ready) begin
               if (flush) begin
                  pc_d       = redirect_even;
                  req_addr_d = redirect_even;
               end else if (stall) begin
                  buf_d = imem.imem_data;
                  pc_d  = pc_plus2;
               end else begin
                  instr_d    = imem.imem_data;
                  out_pc_d   = pc_plus2;
                  valid_d    = 1'b1;
                  pc_d       = pc_plus2;
                  req_addr_d = pc_plus2;
                  halted_d   = data_is_halt;
               end
            end else if (flush) begin
               pc_d = redirect_even;
            end
         end
         S_DRAIN: begin
            // The stale request completes here; restart at the newest target
            if (imem.imem_ready) begin
               pc_d       = flush ? redirect_even : pc_q;
               req_addr_d = flush ? redirect_even : pc_q;
            end else if (flush) begin
               pc_d = redirect_even;
            end
         end
         S_HOLD: begin
            if (flush) begin
               pc_d       = redirect_even;
               req_addr_d = redirect_even;
            end else if (!stall) begin
               instr_d    = buf_q;
               out_pc_d   = pc_q;
               valid_d    = 1'b1;
               req_addr_d = pc_q;
               halted_d   = buf_is_halt;
            end
         end
         S_HALT: begin
            if (flush) begin
               halted_d   = 1'b0;
               pc_d       = redirect_even;
               req_addr_d = redirect_even;
            end
         end
         default: ;
      endcase
   end

   assign imem.imem_req  = !rst && ((state_q == S_FETCH) || (state_q == S_DRAIN));
   assign imem.imem_addr = req_addr_q;
   assign instruction    = instr_q;
   assign pc             = out_pc_q;
   assign if_valid       = valid_q;
   assign halted         = halted_q;

endmodule

`default_nettype wire
